// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo controller, its monitor and their benches:
// light encodings, decoded phase codes and default phase lengths.
package semaforo_pkg;

    localparam logic [2:0] VERDE_C    = 3'b001;
    localparam logic [2:0] AMARELO_C  = 3'b010;
    localparam logic [2:0] VERMELHO_C = 3'b100;

    typedef enum logic [1:0] {
        FASE_VERDE    = 2'd0,
        FASE_AMARELO  = 2'd1,
        FASE_VERMELHO = 2'd2,
        FASE_INVALIDA = 2'd3
    } fase_t;

    localparam logic [7:0] T_VERDE_DEF    = 8'd1;
    localparam logic [7:0] T_AMARELO_DEF  = 8'd3;
    localparam logic [7:0] T_VERMELHO_DEF = 8'd2;

    function automatic fase_t decodifica(input logic [2:0] luz);
        fase_t f;
        case (luz)
            VERDE_C:    f = FASE_VERDE;
            AMARELO_C:  f = FASE_AMARELO;
            VERMELHO_C: f = FASE_VERMELHO;
            default:    f = FASE_INVALIDA;
        endcase
        return f;
    endfunction

    // Only legal successor of each phase.
    function automatic fase_t proxima(input fase_t atual);
        fase_t f;
        case (atual)
            FASE_VERDE:    f = FASE_AMARELO;
            FASE_AMARELO:  f = FASE_VERMELHO;
            FASE_VERMELHO: f = FASE_VERDE;
            default:       f = FASE_INVALIDA;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/semaforo_monitor_fase_checker.sv
// Per-light checker: decodes one light, times the current phase and flags
// illegal codes, illegal transitions and out-of-range phase lengths (single-cycle pulses).
module semaforo_monitor_fase_checker
    import semaforo_pkg::*;
#(
    parameter logic [7:0] T_VERDE    = T_VERDE_DEF,
    parameter logic [7:0] T_AMARELO  = T_AMARELO_DEF,
    parameter logic [7:0] T_VERMELHO = T_VERMELHO_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_luz,
    output fase_t      o_fase,
    output fase_t      o_dec,
    output logic       o_erro_cod,
    output logic       o_erro_ordem,
    output logic       o_erro_tempo,
    output logic       o_fim_ciclo
);

    fase_t      r_fase;
    logic [7:0] r_cnt;
    logic       r_primeira;
    logic       r_limpo;

    fase_t      w_dec;
    fase_t      w_fase_nx;
    logic [7:0] w_cnt_nx;
    logic       w_primeira_nx;
    logic       w_limpo_nx;
    logic       w_erro_cod;
    logic       w_erro_ordem;
    logic       w_erro_tempo;
    logic       w_fim_ciclo;

    // Next-state and check logic for one sampled light code.
    // r_limpo: a verde entry was seen with no invalid code since; a completed
    // cycle is only counted when the vermelho->verde exit closes such a span.
    always_comb begin
        w_dec         = decodifica(i_luz);
        w_fase_nx     = r_fase;
        w_cnt_nx      = r_cnt;
        w_primeira_nx = r_primeira;
        w_limpo_nx    = r_limpo;
        w_erro_cod    = 1'b0;
        w_erro_ordem  = 1'b0;
        w_erro_tempo  = 1'b0;
        w_fim_ciclo   = 1'b0;
        if (w_dec == FASE_INVALIDA) begin
            w_erro_cod    = 1'b1;
            w_fase_nx     = FASE_INVALIDA;
            w_cnt_nx      = 8'd0;
            w_primeira_nx = 1'b1;
            w_limpo_nx    = 1'b0;
        end else if (r_fase == FASE_INVALIDA) begin
            w_fase_nx  = w_dec;
            w_cnt_nx   = 8'd1;
            w_limpo_nx = (w_dec == FASE_VERDE);
        end else if (w_dec == r_fase) begin
            if (r_cnt == 8'hFF) begin
                w_cnt_nx = r_cnt;
            end else begin
                w_cnt_nx = r_cnt + 8'd1;
            end
        end else begin
            w_erro_ordem = (w_dec != proxima(r_fase));
            if (!r_primeira) begin
                case (r_fase)
                    FASE_VERDE:    w_erro_tempo = (r_cnt < T_VERDE);
                    FASE_AMARELO:  w_erro_tempo = (r_cnt != T_AMARELO);
                    FASE_VERMELHO: w_erro_tempo = (r_cnt < T_VERMELHO);
                    default:       w_erro_tempo = 1'b0;
                endcase
            end else begin
                w_erro_tempo = 1'b0;
            end
            w_fim_ciclo   = (r_fase == FASE_VERMELHO) && (w_dec == FASE_VERDE)
                            && !r_primeira && r_limpo;
            w_limpo_nx    = (w_dec == FASE_VERDE) ? 1'b1 : r_limpo;
            w_fase_nx     = w_dec;
            w_cnt_nx      = 8'd1;
            w_primeira_nx = 1'b0;
        end
    end

    // Phase, duration and history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fase     <= FASE_INVALIDA;
            r_cnt      <= 8'd0;
            r_primeira <= 1'b1;
            r_limpo    <= 1'b0;
        end else begin
            r_fase     <= w_fase_nx;
            r_cnt      <= w_cnt_nx;
            r_primeira <= w_primeira_nx;
            r_limpo    <= w_limpo_nx;
        end
    end

    assign o_fase       = r_fase;
    assign o_dec        = w_dec;
    assign o_erro_cod   = w_erro_cod;
    assign o_erro_ordem = w_erro_ordem;
    assign o_erro_tempo = w_erro_tempo;
    assign o_fim_ciclo  = w_fim_ciclo;

endmodule

// File: rtl/semaforo_monitor.sv
// Passive monitor for the two semaforo lights: sticky error flags, conflict
// detection and a saturating count of completed A cycles. Never drives A/B.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter logic [7:0] T_VERDE    = T_VERDE_DEF,
    parameter logic [7:0] T_AMARELO  = T_AMARELO_DEF,
    parameter logic [7:0] T_VERMELHO = T_VERMELHO_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  A,
    input  logic [2:0]  B,
    output logic [1:0]  fase_a,
    output logic [1:0]  fase_b,
    output logic        err_cod,
    output logic        err_confl,
    output logic        err_ordem,
    output logic        err_tempo,
    output logic        err,
    output logic [15:0] ciclos
);

    fase_t       w_fase_a;
    fase_t       w_fase_b;
    fase_t       w_dec_a;
    fase_t       w_dec_b;
    logic        w_cod_a;
    logic        w_cod_b;
    logic        w_ordem_a;
    logic        w_ordem_b;
    logic        w_tempo_a;
    logic        w_tempo_b;
    logic        w_fim_a;
    logic        w_unused_fim_b;

    logic        r_err_cod;
    logic        r_err_confl;
    logic        r_err_ordem;
    logic        r_err_tempo;
    logic        r_err;
    logic [15:0] r_ciclos;

    logic        w_confl;
    logic        w_cod_nx;
    logic        w_confl_nx;
    logic        w_ordem_nx;
    logic        w_tempo_nx;
    logic [15:0] w_ciclos_nx;

    semaforo_monitor_fase_checker #(
        .T_VERDE    (T_VERDE),
        .T_AMARELO  (T_AMARELO),
        .T_VERMELHO (T_VERMELHO)
    ) u_checker_a (
        .clk          (clk),
        .rst          (rst),
        .i_luz        (A),
        .o_fase       (w_fase_a),
        .o_dec        (w_dec_a),
        .o_erro_cod   (w_cod_a),
        .o_erro_ordem (w_ordem_a),
        .o_erro_tempo (w_tempo_a),
        .o_fim_ciclo  (w_fim_a)
    );

    semaforo_monitor_fase_checker #(
        .T_VERDE    (T_VERDE),
        .T_AMARELO  (T_AMARELO),
        .T_VERMELHO (T_VERMELHO)
    ) u_checker_b (
        .clk          (clk),
        .rst          (rst),
        .i_luz        (B),
        .o_fase       (w_fase_b),
        .o_dec        (w_dec_b),
        .o_erro_cod   (w_cod_b),
        .o_erro_ordem (w_ordem_b),
        .o_erro_tempo (w_tempo_b),
        .o_fim_ciclo  (w_unused_fim_b)
    );

    // Sticky flag accumulation, conflict check and cycle counter next value.
    always_comb begin
        w_confl    = ((w_dec_a == FASE_VERDE) || (w_dec_a == FASE_AMARELO))
                     && ((w_dec_b == FASE_VERDE) || (w_dec_b == FASE_AMARELO));
        w_cod_nx   = r_err_cod   | w_cod_a   | w_cod_b;
        w_confl_nx = r_err_confl | w_confl;
        w_ordem_nx = r_err_ordem | w_ordem_a | w_ordem_b;
        w_tempo_nx = r_err_tempo | w_tempo_a | w_tempo_b;
        if (w_fim_a && (r_ciclos != 16'hFFFF)) begin
            w_ciclos_nx = r_ciclos + 16'd1;
        end else begin
            w_ciclos_nx = r_ciclos;
        end
    end

    // Output registers; flags only clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cod   <= 1'b0;
            r_err_confl <= 1'b0;
            r_err_ordem <= 1'b0;
            r_err_tempo <= 1'b0;
            r_err       <= 1'b0;
            r_ciclos    <= 16'd0;
        end else begin
            r_err_cod   <= w_cod_nx;
            r_err_confl <= w_confl_nx;
            r_err_ordem <= w_ordem_nx;
            r_err_tempo <= w_tempo_nx;
            r_err       <= w_cod_nx | w_confl_nx | w_ordem_nx | w_tempo_nx;
            r_ciclos    <= w_ciclos_nx;
        end
    end

    assign fase_a    = w_fase_a;
    assign fase_b    = w_fase_b;
    assign err_cod   = r_err_cod;
    assign err_confl = r_err_confl;
    assign err_ordem = r_err_ordem;
    assign err_tempo = r_err_tempo;
    assign err       = r_err;
    assign ciclos    = r_ciclos;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: the driver pushes hand-computed expectations
// per driven cycle, a monitor pops and compares them after every rising edge.
module tb_semaforo_monitor;
    import semaforo_pkg::*;

    localparam logic [3:0] F_COD   = 4'b1000;
    localparam logic [3:0] F_CONFL = 4'b0100;
    localparam logic [3:0] F_ORDEM = 4'b0010;
    localparam logic [3:0] F_TEMPO = 4'b0001;
    localparam logic [3:0] F_NONE  = 4'b0000;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  fl;
        logic [15:0] cy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  A = 3'b000;
    logic [2:0]  B = 3'b000;
    logic [1:0]  fase_a;
    logic [1:0]  fase_b;
    logic        err_cod;
    logic        err_confl;
    logic        err_ordem;
    logic        err_tempo;
    logic        err;
    logic [15:0] ciclos;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    semaforo_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .fase_a    (fase_a),
        .fase_b    (fase_b),
        .err_cod   (err_cod),
        .err_confl (err_confl),
        .err_ordem (err_ordem),
        .err_tempo (err_tempo),
        .err       (err),
        .ciclos    (ciclos)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fase_de(input logic [2:0] luz);
        case (luz)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive one cycle and queue what must follow the next rising edge.
    task automatic step(input logic [2:0] a, input logic [2:0] b,
                        input logic [3:0] fl, input logic [15:0] cy);
        exp_t e;
        A = a;
        B = b;
        e.fa = fase_de(a);
        e.fb = fase_de(b);
        e.fl = fl;
        e.cy = cy;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] a, input logic [2:0] b, input int n,
                       input logic [3:0] fl, input logic [15:0] cy);
        for (int i = 0; i < n; i++) step(a, b, fl, cy);
    endtask

    // Asserts reset between edges and checks it acts before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_fase_a", fase_a, 2'd3);
        chk("rst_fase_b", fase_b, 2'd3);
        chk("rst_flags", {err_cod, err_confl, err_ordem, err_tempo}, 4'b0000);
        chk("rst_err", err, 1'b0);
        chk("rst_ciclos", ciclos, 16'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fase_a", fase_a, e.fa);
                chk("fase_b", fase_b, e.fb);
                chk("flags", {err_cod, err_confl, err_ordem, err_tempo}, e.fl);
                chk("err", err, |e.fl);
                chk("ciclos", ciclos, e.cy);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        @(negedge clk);
        // 1: legal A sequence, B held red
        do_reset();
        run(VERDE_C, VERMELHO_C, 1, F_NONE, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            run(AMARELO_C,  VERMELHO_C, 3, F_NONE, 16'(k - 1));
            run(VERMELHO_C, VERMELHO_C, 2, F_NONE, 16'(k - 1));
            run(VERDE_C,    VERMELHO_C, 1, F_NONE, 16'(k));
        end
        // 2: yellow held 4 cycles
        run(AMARELO_C,  VERMELHO_C, 4, F_NONE,  16'd3);
        run(VERMELHO_C, VERMELHO_C, 2, F_TEMPO, 16'd3);
        run(VERDE_C,    VERMELHO_C, 1, F_TEMPO, 16'd4);
        // 3: illegal code, following partial phase untimed
        do_reset();
        run(VERDE_C,    VERMELHO_C, 1, F_NONE, 16'd0);
        run(AMARELO_C,  VERMELHO_C, 3, F_NONE, 16'd0);
        run(VERMELHO_C, VERMELHO_C, 2, F_NONE, 16'd0);
        run(3'b011,     VERMELHO_C, 1, F_COD,  16'd0);
        run(VERMELHO_C, VERMELHO_C, 1, F_COD,  16'd0);
        run(VERDE_C,    VERMELHO_C, 1, F_COD,  16'd0);
        run(AMARELO_C,  VERMELHO_C, 3, F_COD,  16'd0);
        run(VERMELHO_C, VERMELHO_C, 2, F_COD,  16'd0);
        run(VERDE_C,    VERMELHO_C, 1, F_COD,  16'd1);
        // 4: both green, then A verde->vermelho
        do_reset();
        run(VERDE_C,    VERDE_C,    1, F_CONFL, 16'd0);
        run(VERDE_C,    AMARELO_C,  3, F_CONFL, 16'd0);
        run(VERDE_C,    VERMELHO_C, 1, F_CONFL, 16'd0);
        run(VERMELHO_C, VERMELHO_C, 2, F_CONFL | F_ORDEM, 16'd0);
        // 5: start mid-amarelo, then async reset mid-phase
        do_reset();
        run(AMARELO_C,  VERMELHO_C, 1, F_NONE, 16'd0);
        run(VERMELHO_C, VERMELHO_C, 2, F_NONE, 16'd0);
        run(VERDE_C,    VERMELHO_C, 1, F_NONE, 16'd0);
        run(AMARELO_C,  VERMELHO_C, 3, F_NONE, 16'd0);
        run(VERMELHO_C, VERMELHO_C, 2, F_NONE, 16'd0);
        run(VERDE_C,    VERMELHO_C, 1, F_NONE, 16'd1);
        run(3'b111,     VERMELHO_C, 1, F_COD,  16'd1);
        run(AMARELO_C,  VERMELHO_C, 2, F_COD,  16'd1);
        do_reset();
        run(VERDE_C,    VERMELHO_C, 1, F_NONE, 16'd0);
        // 6: long green saturates counter; 259-cycle yellow must not wrap to 3
        do_reset();
        run(VERDE_C,    VERMELHO_C, 1,   F_NONE,  16'd0);
        run(AMARELO_C,  VERMELHO_C, 3,   F_NONE,  16'd0);
        run(VERMELHO_C, VERMELHO_C, 2,   F_NONE,  16'd0);
        run(VERDE_C,    VERMELHO_C, 300, F_NONE,  16'd1);
        run(AMARELO_C,  VERMELHO_C, 3,   F_NONE,  16'd1);
        run(VERMELHO_C, VERMELHO_C, 2,   F_NONE,  16'd1);
        run(VERDE_C,    VERMELHO_C, 1,   F_NONE,  16'd2);
        run(AMARELO_C,  VERMELHO_C, 259, F_NONE,  16'd2);
        run(VERMELHO_C, VERMELHO_C, 1,   F_TEMPO, 16'd2);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
